// File: rtl/armleo_regfile_pkg.sv
// Shared types for the armleo integer register file: read-select encoding and sweep/run FSM.
package armleo_regfile_pkg;

    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_MEM    = 2'd1,
        SEL_BYPASS = 2'd2
    } sel_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/armleo_regfile_mem_1r1w.sv
// Single-write, single-read synchronous memory; read-first, read data holds while read is low.
module armleo_mem_1r1w #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  read,
    input  logic [DEPTH_LOG2-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data,
    input  logic                  write,
    input  logic [DEPTH_LOG2-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data
);

    localparam int unsigned ELEMENTS = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] storage [ELEMENTS];

    // Both accesses on the same edge: the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (write) begin
            storage[write_addr] <= write_data;
        end
        if (read) begin
            read_data <= storage[read_addr];
        end
    end

endmodule

// File: rtl/armleo_regfile.sv
// Two-read, one-write register file with zero register, write forwarding and a post-reset clearing sweep.
module armleo_regfile
    import armleo_regfile_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WIDTH      = 32,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  rs1_read,
    input  logic [DEPTH_LOG2-1:0] rs1_addr,
    output logic [WIDTH-1:0]      rs1_data,
    input  logic                  rs2_read,
    input  logic [DEPTH_LOG2-1:0] rs2_addr,
    output logic [WIDTH-1:0]      rs2_data,
    input  logic                  rd_write,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_wdata
);

    localparam int unsigned ELEMENTS = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_ENTRY = DEPTH_LOG2'(ELEMENTS - 1);

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   counter;
    sel_t                    sel1;
    sel_t                    sel2;
    logic [WIDTH-1:0]        bypass1;
    logic [WIDTH-1:0]        bypass2;
    logic [WIDTH-1:0]        mem1_data;
    logic [WIDTH-1:0]        mem2_data;

    logic                    write_effective;
    logic                    mem_write;
    logic [DEPTH_LOG2-1:0]   mem_write_addr;
    logic [WIDTH-1:0]        mem_write_data;
    logic                    mem1_read;
    logic                    mem2_read;

    assign write_effective = ready && rd_write && ((rd_addr != '0) || !ZERO_REG);
    assign mem1_read       = rs1_read && ready;
    assign mem2_read       = rs2_read && ready;

    // Shared write port: clearing sweep owns it until the FSM reaches RUN.
    always_comb begin
        mem_write      = write_effective;
        mem_write_addr = rd_addr;
        mem_write_data = rd_wdata;
        if (state == INIT) begin
            mem_write      = 1'b1;
            mem_write_addr = counter;
            mem_write_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            counter <= '0;
            ready   <= 1'b0;
            sel1    <= SEL_ZERO;
            sel2    <= SEL_ZERO;
            bypass1 <= '0;
            bypass2 <= '0;
        end else begin
            case (state)
                INIT: begin
                    counter <= counter + DEPTH_LOG2'(1);
                    if (counter == LAST_ENTRY) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Memories are read-first, so a same-edge write must be forwarded.
                    if (rs1_read) begin
                        if (ZERO_REG && (rs1_addr == '0)) begin
                            sel1 <= SEL_ZERO;
                        end else if (write_effective && (rd_addr == rs1_addr)) begin
                            sel1    <= SEL_BYPASS;
                            bypass1 <= rd_wdata;
                        end else begin
                            sel1 <= SEL_MEM;
                        end
                    end
                    if (rs2_read) begin
                        if (ZERO_REG && (rs2_addr == '0)) begin
                            sel2 <= SEL_ZERO;
                        end else if (write_effective && (rd_addr == rs2_addr)) begin
                            sel2    <= SEL_BYPASS;
                            bypass2 <= rd_wdata;
                        end else begin
                            sel2 <= SEL_MEM;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    always_comb begin
        rs1_data = '0;
        case (sel1)
            SEL_MEM:    rs1_data = mem1_data;
            SEL_BYPASS: rs1_data = bypass1;
            default:    rs1_data = '0;
        endcase
    end

    always_comb begin
        rs2_data = '0;
        case (sel2)
            SEL_MEM:    rs2_data = mem2_data;
            SEL_BYPASS: rs2_data = bypass2;
            default:    rs2_data = '0;
        endcase
    end

    armleo_mem_1r1w #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem1 (
        .clk        (clk),
        .read       (mem1_read),
        .read_addr  (rs1_addr),
        .read_data  (mem1_data),
        .write      (mem_write),
        .write_addr (mem_write_addr),
        .write_data (mem_write_data)
    );

    armleo_mem_1r1w #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem2 (
        .clk        (clk),
        .read       (mem2_read),
        .read_addr  (rs2_addr),
        .read_data  (mem2_data),
        .write      (mem_write),
        .write_addr (mem_write_addr),
        .write_data (mem_write_data)
    );

endmodule

// File: tb/tb_armleo_regfile.sv
// Scoreboard bench for armleo_regfile: one instance with ZERO_REG=1 (a) and one with ZERO_REG=0 (b), shared stimulus.
module tb_armleo_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs1_read, rs2_read, rd_write;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rd_wdata;

    logic        ready_a, ready_b;
    logic [31:0] rs1_data_a, rs2_data_a, rs1_data_b, rs2_data_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    // Reference model state, index 0 = instance a (ZERO_REG=1), 1 = instance b (ZERO_REG=0)
    logic [31:0] model_mem [2][32];
    logic [31:0] exp_rs1 [2];
    logic [31:0] exp_rs2 [2];
    bit          model_ready;
    int          sweep_count;

    always #5 clk = ~clk;

    armleo_regfile #(.DEPTH_LOG2(5), .WIDTH(32), .ZERO_REG(1'b1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready_a),
        .rs1_read (rs1_read),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data_a),
        .rs2_read (rs2_read),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data_a),
        .rd_write (rd_write),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata)
    );

    armleo_regfile #(.DEPTH_LOG2(5), .WIDTH(32), .ZERO_REG(1'b0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready_b),
        .rs1_read (rs1_read),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data_b),
        .rs2_read (rs2_read),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data_b),
        .rd_write (rd_write),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_all(input string tag);
        sb_q.push_back('{$sformatf("%s.a.rs1", tag), exp_rs1[0]});
        sb_q.push_back('{$sformatf("%s.a.rs2", tag), exp_rs2[0]});
        sb_q.push_back('{$sformatf("%s.b.rs1", tag), exp_rs1[1]});
        sb_q.push_back('{$sformatf("%s.b.rs2", tag), exp_rs2[1]});
        sb_q.push_back('{$sformatf("%s.a.ready", tag), 32'(model_ready)});
        sb_q.push_back('{$sformatf("%s.b.ready", tag), 32'(model_ready)});
    endtask

    task automatic pop_all();
        logic [31:0] obs [6];
        sb_t         e;
        obs[0] = rs1_data_a;
        obs[1] = rs2_data_a;
        obs[2] = rs1_data_b;
        obs[3] = rs2_data_b;
        obs[4] = 32'(ready_a);
        obs[5] = 32'(ready_b);
        for (int i = 0; i < 6; i++) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk(e.tag, obs[i], e.exp);
            end
        end
    endtask

    // One clock of stimulus: drive, predict, clock, compare.
    task automatic step(input bit r1, input logic [4:0] a1, input bit r2, input logic [4:0] a2,
                        input bit w, input logic [4:0] wa, input logic [31:0] wd, input string tag);
        bit zr;
        bit weff;
        rs1_read = r1; rs1_addr = a1;
        rs2_read = r2; rs2_addr = a2;
        rd_write = w;  rd_addr = wa;  rd_wdata = wd;
        if (model_ready) begin
            for (int d = 0; d < 2; d++) begin
                zr   = (d == 0);
                weff = w && ((wa != 5'd0) || !zr);
                if (r1) exp_rs1[d] = (zr && a1 == 5'd0) ? 32'd0 : ((weff && wa == a1) ? wd : model_mem[d][a1]);
                if (r2) exp_rs2[d] = (zr && a2 == 5'd0) ? 32'd0 : ((weff && wa == a2) ? wd : model_mem[d][a2]);
                if (weff) model_mem[d][wa] = wd;
            end
        end else begin
            sweep_count++;
            if (sweep_count == 32) begin
                model_ready = 1'b1;
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 32; k++) model_mem[d][k] = 32'd0;
            end
        end
        push_all(tag);
        @(posedge clk);
        #1;
        pop_all();
    endtask

    // Asynchronous reset pulse applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_ready = 1'b0;
        sweep_count = 0;
        for (int d = 0; d < 2; d++) begin
            exp_rs1[d] = 32'd0;
            exp_rs2[d] = 32'd0;
        end
        #1;
        push_all(tag);
        pop_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rs1_read = 1'b0; rs1_addr = '0;
        rs2_read = 1'b0; rs2_addr = '0;
        rd_write = 1'b0; rd_addr = '0; rd_wdata = '0;
        model_ready = 1'b0;
        sweep_count = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Sweep with requests that must be ignored, including a write to x9
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'd9, 1'b1, 5'(i), 1'b1, 5'd9, 32'h0000_0055, $sformatf("sweep%0d", i));
        end

        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, $sformatf("clear_rd%0d", i));
        end

        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, "wr_x5");
        step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "rd_x5");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'(i), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, $sformatf("hold%0d", i));
        end

        step(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 32'h1234_5678, "fwd_x7");
        step(1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, "mem_x7");

        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, "wr_x0");
        step(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, "rd_x0");
        step(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 32'h0BAD_F00D, "fwd_x0");

        // Reset in the middle of the sweep, then run a full sweep again
        do_reset("reset2");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, $sformatf("part%0d", i));
        end
        do_reset("reset3");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, $sformatf("sweepb%0d", i));
        end

        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5, "wr_x3");
        step(1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, "rd_x3");
        do_reset("reset4");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, $sformatf("sweepc%0d", i));
        end
        step(1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, "post_rst_x3");
        step(1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, "post_rst_x7");

        // Mixed traffic over a small address set so forwarding and aliasing hit often
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 32'($urandom), $sformatf("mix%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
